m_key_event_fifo: RTL and testbench
===================================

// Module: m_key_event_fifo
// PURPOSE
//  Downstream of the 16-to-4 calculator key decoder. Samples {pushed, code} once per scan-complete strobe (tc).
//  Debounces each press and emits exactly one key event per press.
//  Buffers events in a small first-word-fall-through FIFO with a valid/ready handshake to the calculator core.
// PARAMETERS
//  STABLE_SCANS  3   identical consecutive tc samples needed to accept a press or a release (legal range 2..15)
//  FIFO_DEPTH    4   event FIFO entries; must be a power of 2, >=2
//  REPEAT_DELAY  50  tc samples held before the first auto-repeat (used only with KEY_REPEAT_EN)
//  REPEAT_RATE   10  tc samples between later auto-repeats (used only with KEY_REPEAT_EN)
// PORTS
//  clk        in   1                      system clock
//  rst        in   1                      asynchronous reset, active-low (rst==0 resets)
//  tc         in   1                      scan-complete strobe; pushed/code are sampled only when tc==1
//  pushed     in   1                      decoder: exactly one key down
//  code       in   4                      decoder key code (valid when pushed==1)
//  ev_valid   out  1                      FIFO non-empty
//  ev_code    out  4                      FIFO head code (FWFT)
//  ev_ready   in   1                      consumer accepts the head when ev_valid && ev_ready
//  ovf_clr    in   1                      synchronous clear of overflow
//  overflow   out  1                      sticky: an event was dropped
//  ev_count   out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
// BEHAVIOUR
//  Reset: FSM=IDLE, cand=0, cnt=0, FIFO empty, ev_valid=0, ev_code=0, overflow=0, ev_count=0. Takes effect immediately.
//   Reset mid-press or mid-drain discards all state; a new press needs the full STABLE_SCANS.
//  pushed==0 (no key or multiple keys) counts as released.
//  Debounce FSM (advances only on clk edges with tc==1):
//   IDLE:      pushed -> cand<=code, cnt<=1, PRESS_CHK.
//   PRESS_CHK: pushed && code==cand -> cnt++; on reaching STABLE_SCANS push cand, go to HELD.
//              pushed && code!=cand -> cand<=code, cnt<=1.
//              !pushed -> IDLE.
//   HELD:      !pushed -> cnt<=1, REL_CHK. pushed with any code -> stay; a new code is ignored until release.
//   REL_CHK:   !pushed -> cnt++; on reaching STABLE_SCANS go to IDLE. pushed -> HELD, no new event.
//  Latency: push occurs on the edge of the accepting tc sample; ev_valid=1 on the next cycle when the FIFO was empty.
//  FIFO:
//   pop = ev_valid && ev_ready.
//   Push when full without a same-cycle pop -> new event dropped, overflow<=1.
//   Push and pop in the same cycle when full -> both happen, count unchanged, no overflow.
//   Pointers wrap modulo FIFO_DEPTH. ev_code is held stable while ev_valid && !ev_ready.
//  overflow: ovf_clr has priority over a same-cycle set.
// CONFIGURATION
//  KEY_REPEAT_EN defined:
//   Scan counter rcnt is zeroed on PRESS_CHK->HELD, increments per tc in HELD, and is frozen in REL_CHK.
//   Pushes cand again at rcnt==REPEAT_DELAY, then every REPEAT_RATE samples.
//  KEY_REPEAT_EN undefined: one event per press; REPEAT_* parameters are unused; no rcnt logic.
// TESTING
//  1. tc every 8 clk; pushed=1, code=5 for 3 samples, then 3 released samples
//     -> one event, code 5; ev_valid rises 1 clk after the 3rd sample; FSM back in IDLE.
//  2. Bounce: pushed sequence 1,0,1,1,0,0,0 (code 2) -> no event; ev_count stays 0.
//  3. Code change: samples code 3,3,7,7,7 -> exactly one event, code 7.
//  4. ev_ready=0; 6 distinct presses (1..6) -> ev_count=4, overflow=1; drain gives 1,2,3,4;
//     ovf_clr -> overflow=0. Repeat with a pop aligned to the 5th push -> no overflow, count stays 4.
//  5. rst=0 mid-PRESS_CHK with 2 events queued -> ev_valid=0, ev_count=0 at once;
//     after release, the next press needs 3 samples.
//  6. KEY_REPEAT_EN: hold code 9 for 70 samples -> events at samples 3, 53 and 63; without the macro -> one event.

Source files
------------

// File: rtl/m_key_event_fifo.sv
// rtl/m_key_event_fifo.sv - debounced one-event-per-press key FIFO behind the keypad decoder
// Auto-repeat of a held key is compiled in when KEY_REPEAT_EN is defined.
module m_key_event_fifo #(
   parameter int STABLE_SCANS = 3,
   parameter int FIFO_DEPTH   = 4,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tc,
   input  logic                          pushed,
   input  logic [3:0]                    code,
   output logic                          ev_valid,
   output logic [3:0]                    ev_code,
   input  logic                          ev_ready,
   input  logic                          ovf_clr,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   ev_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [3:0]    STABLE   = 4'(STABLE_SCANS);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

   state_t     state, state_n;
   logic [3:0] cand, cand_n;
   logic [3:0] cnt, cnt_n, cnt_inc;
   logic       press_push;
   logic       push;

   assign cnt_inc = cnt + 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cand  <= 4'd0;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cand  <= cand_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      if (tc) begin
         case (state)
            IDLE: begin
               if (pushed) begin
                  cand_n  = code;
                  cnt_n   = 4'd1;
                  state_n = PRESS_CHK;
               end
            end
            PRESS_CHK: begin
               if (!pushed) begin
                  state_n = IDLE;
               end else if (code == cand) begin
                  cnt_n = cnt_inc;
                  if (cnt_inc == STABLE) state_n = HELD;
               end else begin
                  cand_n = code;
                  cnt_n  = 4'd1;
               end
            end
            HELD: begin
               // a different code while held is ignored until a full release
               if (!pushed) begin
                  cnt_n   = 4'd1;
                  state_n = REL_CHK;
               end
            end
            REL_CHK: begin
               if (pushed) begin
                  state_n = HELD;
               end else begin
                  cnt_n = cnt_inc;
                  if (cnt_inc == STABLE) state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      press_push = 1'b0;
      if (tc && state == PRESS_CHK && pushed && code == cand && cnt_inc == STABLE)
         press_push = 1'b1;
   end

`ifdef KEY_REPEAT_EN
   localparam int RW = $clog2(REPEAT_DELAY + 1);
   localparam logic [RW-1:0] RCNT_ONE   = RW'(1);
   localparam logic [RW-1:0] RCNT_FIRST = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] RCNT_RELD  = RW'(REPEAT_DELAY - REPEAT_RATE);

   logic [RW-1:0] rcnt, rcnt_inc;
   logic          rep_push;

   assign rcnt_inc = rcnt + RCNT_ONE;
   assign rep_push = tc && state == HELD && pushed && rcnt_inc == RCNT_FIRST;
   assign push     = press_push | rep_push;

   // reloading after each repeat makes later repeats land REPEAT_RATE samples apart
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rcnt <= '0;
      else if (press_push)
         rcnt <= '0;
      else if (tc && state == HELD && pushed)
         rcnt <= rep_push ? RCNT_RELD : rcnt_inc;
   end
`else
   assign push = press_push;
`endif

   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, pop, wr_en;

   assign full     = (count == FULL_CNT);
   assign pop      = ev_valid && ev_ready;
   assign wr_en    = push && (!full || pop);
   assign ev_valid = (count != '0);
   assign ev_code  = ev_valid ? mem[rd_ptr] : 4'd0;
   assign ev_count = count;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= cand;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_en, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (ovf_clr)
            overflow <= 1'b0;
         else if (push && full && !pop)
            overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_m_key_event_fifo.sv
// tb/tb_m_key_event_fifo.sv - randomized bench for m_key_event_fifo against a sliding-window model
module tb_m_key_event_fifo;
   localparam int S = 3;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tc = 1'b0;
   logic       pushed = 1'b0;
   logic [3:0] code = 4'd0;
   logic       ev_ready = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       ev_valid;
   logic [3:0] ev_code;
   logic       overflow;
   logic [2:0] ev_count;

   m_key_event_fifo #(.STABLE_SCANS(S), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .tc(tc), .pushed(pushed), .code(code),
      .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
      .ovf_clr(ovf_clr), .overflow(overflow), .ev_count(ev_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check_val(string tag, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
   endtask

   // model: a press is the last S samples all pushed with one code; a release is the last S all released
   logic [4:0] win[$];
   bit         held;
   int         fq[$];
   bit         m_ovf;

   task automatic model_reset();
      win.delete();
      held  = 0;
      fq.delete();
      m_ovf = 0;
   endtask

   task automatic drive(bit t, bit p, logic [3:0] c, bit r, bit clr);
      tc = t; pushed = p; code = c; ev_ready = r; ovf_clr = clr;
      @(posedge clk);
      #1;
      @(negedge clk);
   endtask

   task automatic cyc(bit t, bit p, logic [3:0] c, bit r, bit clr);
      bit ev = 0;
      bit pop;
      int sz;
      pop = (fq.size() > 0) && r;
      if (t) begin
         win.push_back({p, c});
         if (win.size() > S) void'(win.pop_front());
         if (win.size() == S) begin
            bit allp = 1;
            bit allr = 1;
            foreach (win[i]) begin
               if (!win[i][4] || win[i][3:0] != win[0][3:0]) allp = 0;
               if (win[i][4]) allr = 0;
            end
            if (!held && allp) begin
               ev = 1;
               held = 1;
            end else if (held && allr) begin
               held = 0;
            end
         end
      end
      sz = fq.size();
      if (pop) void'(fq.pop_front());
      if (ev) begin
         if (sz < D || pop) fq.push_back(int'(win[S-1][3:0]));
         else m_ovf = 1;
      end
      if (clr) m_ovf = 0;
      tc = t; pushed = p; code = c; ev_ready = r; ovf_clr = clr;
      @(posedge clk);
      #1;
      check_val("ev_valid", ev_valid, fq.size() > 0);
      check_val("ev_count", ev_count, fq.size());
      check_val("ev_code", ev_code, fq.size() > 0 ? fq[0] : 0);
      check_val("overflow", overflow, m_ovf);
      @(negedge clk);
   endtask

   task automatic scan(bit p, logic [3:0] c, bit r);
      cyc(1, p, c, r, 0);
      repeat (7) cyc(0, p, c, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tc = 1'b0;
      #1;
      check_val("rst_valid", ev_valid, 0);
      check_val("rst_count", ev_count, 0);
      check_val("rst_ovf", overflow, 0);
      check_val("rst_code", ev_code, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int ev_at[$];
      int exp_at[$];
      #1;
      do_reset();

      // long hold of code 9: one event, or 3/53/63 with auto-repeat
      for (int k = 1; k <= 70; k++) begin
         drive(1, 1, 4'd9, 1, 0);
         if (ev_valid) ev_at.push_back(k);
         repeat (7) drive(0, 1, 4'd9, 1, 0);
      end
`ifdef KEY_REPEAT_EN
      exp_at = '{3, 53, 63};
`else
      exp_at = '{3};
`endif
      check_val("hold_events", ev_at.size(), exp_at.size());
      foreach (exp_at[i])
         check_val("hold_at", i < ev_at.size() ? ev_at[i] : -1, exp_at[i]);
      do_reset();

`ifndef KEY_REPEAT_EN
      // overflow with six presses, drain, clear, then pop aligned with the fifth push
      for (int k = 1; k <= 6; k++) begin
         repeat (3) scan(1, 4'(k), 0);
         repeat (3) scan(0, 4'd0, 0);
      end
      check_val("dir_ovf_set", overflow, 1);
      check_val("dir_full", ev_count, 4);
      for (int k = 1; k <= 4; k++) begin
         check_val("dir_drain", ev_code, k);
         cyc(0, 0, 4'd0, 1, 0);
      end
      cyc(0, 0, 4'd0, 0, 1);
      check_val("dir_ovf_clr", overflow, 0);
      for (int k = 1; k <= 5; k++) begin
         repeat (2) scan(1, 4'(k), 0);
         scan(1, 4'(k), k == 5);
         repeat (3) scan(0, 4'd0, 0);
      end
      check_val("dir_align_cnt", ev_count, 4);
      check_val("dir_align_ovf", overflow, 0);
      do_reset();

      for (int seg = 0; seg < 400; seg++) begin
         bit         p;
         logic [3:0] c;
         int         rdy_pct;
         p = ($urandom_range(0, 3) != 0);
         c = 4'($urandom_range(0, 7));
         rdy_pct = (seg % 100 < 50) ? 15 : 70;
         if ($urandom_range(0, 149) == 0) do_reset();
         repeat ($urandom_range(1, 5)) begin
            cyc(1, p, c, $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 19) == 0);
            repeat ($urandom_range(0, 3))
               cyc(0, p, c, $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 19) == 0);
         end
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
